// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with a valid/ready
// handshake to decode, one-bubble redirect and a sticky fault on a
// misaligned redirect target or an out-of-range fetch address.
//
// Ports:
//   clk                - single clock, all state updates on posedge
//   reset              - synchronous active-low reset
//   imem_cs_o          - instruction memory chip select
//   imem_addr_o        - byte address to instruction memory (current PC)
//   imem_instr_i       - instruction word, valid in the cycle imem_cs_o=1
//   redirect_i         - branch/jump taken; replaces PC
//   redirect_target_i  - redirect byte address
//   ready_i            - decode accepts instr_o this cycle
//   valid_o            - instr_o/pc_o hold a valid fetched instruction
//   instr_o            - registered instruction
//   pc_o               - byte address of instr_o
//   fault_o            - sticky fetch fault
//   fetch_count_o      - number of instructions accepted by decode
//
// state | meaning
// BOOT  | one idle cycle after reset release, no fetch
// RUN   | fetching whenever the output slot is empty or being drained
// STALL | holding a valid instruction that decode has not accepted
// FAULT | fetch stopped, fault_o set; left only by reset
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MEM_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_cs_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Widened by one bit so MEM_WORDS*4 = 2^32 cannot wrap to zero.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        valid_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic        active;
    logic        slot_free;
    logic        transfer;
    logic        out_of_range;

    assign active       = (state_q == RUN) || (state_q == STALL);
    assign slot_free    = !valid_q || ready_i;
    assign transfer     = active && valid_q && ready_i;
    assign out_of_range = ({1'b0, pc_q} >= ADDR_LIMIT);

    // Reset is synchronous, so from the first reset edge the state is BOOT
    // and the select is already low without looking at reset here.
    assign imem_cs_o   = active && !redirect_i && slot_free;
    assign imem_addr_o = pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    if (redirect_i) begin
                        pc_q <= redirect_target_i;
                        if (redirect_target_i[1:0] != 2'b00) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                RUN, STALL: begin
                    if (transfer) begin
                        count_q <= count_q + 32'd1;
                    end
                    if (redirect_i) begin
                        // Any held instruction is dropped; the target is
                        // fetched on the following cycle.
                        valid_q <= 1'b0;
                        pc_q    <= redirect_target_i;
                        if (redirect_target_i[1:0] != 2'b00) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (slot_free) begin
                        if (out_of_range) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            instr_q  <= imem_instr_i;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                            pc_q     <= pc_q + 32'd4;
                            state_q  <= RUN;
                        end
                    end else begin
                        state_q <= STALL;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign valid_o       = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign fault_o       = fault_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_cs_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];

    fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .MEM_WORDS   (1024)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_cs_o        (imem_cs_o),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .ready_i          (ready_i),
        .valid_o          (valid_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .fault_o          (fault_o),
        .fetch_count_o    (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr_i = (imem_addr_o < 32'd4096) ? mem[imem_addr_o[11:2]]
                                                   : 32'hDEAD_BEEF;

    function automatic logic [31:0] word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Two reset edges, then release; returns one cycle into RUN with PC=0.
    task automatic do_reset();
        reset      = 1'b0;
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("boot_cs", {31'd0, imem_cs_o}, 32'd0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word(i);
        reset             = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = 32'd0;
        ready_i           = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_count", fetch_count_o, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_cs", {31'd0, imem_cs_o}, 32'd0);
        reset = 1'b1;
        #1;
        chk("boot_cs0", {31'd0, imem_cs_o}, 32'd0);
        chk("boot_valid", {31'd0, valid_o}, 32'd0);
        step();

        // Streaming fetch A,B,C
        chk("run_cs", {31'd0, imem_cs_o}, 32'd1);
        chk("run_addr", imem_addr_o, 32'h0);
        step();
        chk("a_valid", {31'd0, valid_o}, 32'd1);
        chk("a_instr", instr_o, word(0));
        chk("a_pc", pc_o, 32'h0);
        step();
        chk("b_instr", instr_o, word(1));
        chk("b_pc", pc_o, 32'h4);
        step();
        chk("c_instr", instr_o, word(2));
        chk("c_pc", pc_o, 32'h8);
        chk("c_count", fetch_count_o, 32'd2);
        step();
        chk("three_count", fetch_count_o, 32'd3);

        // Stall while B is held
        do_reset();
        step();
        step();
        chk("s_b_instr", instr_o, word(1));
        ready_i = 1'b0;
        #1;
        chk("s_cs_run", {31'd0, imem_cs_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s_cs", {31'd0, imem_cs_o}, 32'd0);
            chk("s_instr", instr_o, word(1));
            chk("s_pc", pc_o, 32'h4);
            chk("s_valid", {31'd0, valid_o}, 32'd1);
        end
        chk("s_count", fetch_count_o, 32'd1);
        ready_i = 1'b1;
        #1;
        chk("s_rel_cs", {31'd0, imem_cs_o}, 32'd1);
        chk("s_rel_addr", imem_addr_o, 32'h8);
        step();
        chk("s_c_instr", instr_o, word(2));
        chk("s_c_pc", pc_o, 32'h8);
        chk("s_c_count", fetch_count_o, 32'd2);

        // Redirect to 0x40 while pc_o=0x8
        redirect_i        = 1'b1;
        redirect_target_i = 32'h40;
        #1;
        chk("r_cs", {31'd0, imem_cs_o}, 32'd0);
        step();
        redirect_i = 1'b0;
        chk("r_bubble", {31'd0, valid_o}, 32'd0);
        chk("r_count", fetch_count_o, 32'd3);
        chk("r_addr", imem_addr_o, 32'h40);
        step();
        chk("r_valid", {31'd0, valid_o}, 32'd1);
        chk("r_pc", pc_o, 32'h40);
        chk("r_instr", instr_o, word(16));

        // Misaligned redirect -> sticky fault, then reset
        redirect_i        = 1'b1;
        redirect_target_i = 32'h42;
        step();
        redirect_i = 1'b0;
        chk("f_fault", {31'd0, fault_o}, 32'd1);
        chk("f_valid", {31'd0, valid_o}, 32'd0);
        chk("f_cs", {31'd0, imem_cs_o}, 32'd0);
        chk("f_count", fetch_count_o, 32'd4);
        redirect_i        = 1'b1;
        redirect_target_i = 32'h0;
        step();
        step();
        redirect_i = 1'b0;
        chk("f_hold_fault", {31'd0, fault_o}, 32'd1);
        chk("f_hold_valid", {31'd0, valid_o}, 32'd0);
        chk("f_hold_cs", {31'd0, imem_cs_o}, 32'd0);
        chk("f_hold_count", fetch_count_o, 32'd4);
        reset = 1'b0;
        step();
        chk("f_rst_fault", {31'd0, fault_o}, 32'd0);
        chk("f_rst_count", fetch_count_o, 32'd0);
        reset = 1'b1;
        #1;
        chk("f_boot_cs", {31'd0, imem_cs_o}, 32'd0);
        step();
        chk("f_run_cs", {31'd0, imem_cs_o}, 32'd1);
        chk("f_run_addr", imem_addr_o, 32'h0);

        // End of memory: word 1023 delivered, then fault at 0x1000
        redirect_i        = 1'b1;
        redirect_target_i = 32'hFF8;
        step();
        redirect_i = 1'b0;
        chk("e_addr", imem_addr_o, 32'hFF8);
        step();
        chk("e_w1022", instr_o, word(1022));
        step();
        chk("e_w1023", instr_o, word(1023));
        chk("e_pc", pc_o, 32'hFFC);
        chk("e_next_addr", imem_addr_o, 32'h1000);
        chk("e_nofault", {31'd0, fault_o}, 32'd0);
        step();
        chk("e_fault", {31'd0, fault_o}, 32'd1);
        chk("e_valid", {31'd0, valid_o}, 32'd0);
        chk("e_cs", {31'd0, imem_cs_o}, 32'd0);
        chk("e_count", fetch_count_o, 32'd2);

        // Reset during STALL with redirect asserted
        do_reset();
        step();
        ready_i = 1'b0;
        step();
        chk("x_stall_valid", {31'd0, valid_o}, 32'd1);
        chk("x_stall_count", fetch_count_o, 32'd0);
        redirect_i        = 1'b1;
        redirect_target_i = 32'h80;
        ready_i           = 1'b1;
        reset             = 1'b0;
        step();
        chk("x_valid", {31'd0, valid_o}, 32'd0);
        chk("x_count", fetch_count_o, 32'd0);
        chk("x_instr", instr_o, 32'd0);
        chk("x_pc", pc_o, 32'd0);
        chk("x_addr", imem_addr_o, 32'h0);
        reset      = 1'b1;
        redirect_i = 1'b0;
        #1;
        chk("x_boot_cs", {31'd0, imem_cs_o}, 32'd0);
        step();
        chk("x_run_cs", {31'd0, imem_cs_o}, 32'd1);
        chk("x_run_addr", imem_addr_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
